data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 46 ++++
 rtl/data_mem_arbiter.sv | 101 ++++++++++
 tb/tb_data_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings and pipeline record types for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Command presented to memory the cycle after a grant.
  typedef struct packed {
    logic        read;
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Per-request tracking through the two-stage response pipeline.
  typedef struct packed {
    logic valid;
    logic port;
    logic is_load;
  } tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter: round-robin on a last-granted pointer, or fixed priority to port 0.
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_q, last_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if ((RR_ENABLE != 0) && req0 && req1) begin
        // Contested cycle: the port that did not win last time goes next.
        gnt0 = (last_q == PORT_AUX);
        gnt1 = (last_q == PORT_CPU);
      end else begin
        gnt0 = req0;
        gnt1 = req1 && !req0;
      end
    end
    last_d = last_q;
    if (gnt0) begin
      last_d = PORT_CPU;
    end else if (gnt1) begin
      last_d = PORT_AUX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_AUX;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter: grant in N, memory command in N+1, load response in N+2.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned RR_ENABLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_size,
  input  logic        m0_unsigned,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [1:0]  m1_size,
  input  logic        m1_unsigned,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  store_size,
  output logic [1:0]  load_size,
  output logic        load_unsigned,
  output logic [31:0] endereco,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  logic gnt0, gnt1, any_gnt;
  cmd_t cmd_q, cmd_d;
  tag_t tag_s1_q, tag_s1_d, tag_s2_q;
  logic resp_load;

  rr_arbiter2 #(
    .RR_ENABLE(RR_ENABLE)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req0 (m0_req),
    .req1 (m1_req),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    cmd_d       = cmd_q;
    cmd_d.read  = 1'b0;
    cmd_d.write = 1'b0;
    if (any_gnt) begin
      if (gnt1) begin
        cmd_d = '{read: !m1_we, write: m1_we, size: m1_size, uns: m1_unsigned,
                  addr: m1_addr, wdata: m1_wdata};
      end else begin
        cmd_d = '{read: !m0_we, write: m0_we, size: m0_size, uns: m0_unsigned,
                  addr: m0_addr, wdata: m0_wdata};
      end
    end
    tag_s1_d = '{valid: any_gnt, port: gnt1, is_load: any_gnt && !cmd_d.write};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= '0;
      tag_s1_q <= '0;
      tag_s2_q <= '0;
    end else begin
      cmd_q    <= cmd_d;
      tag_s1_q <= tag_s1_d;
      tag_s2_q <= tag_s1_q;
    end
  end

  // Strobes and responses are masked while reset is held so nothing leaks before the clear edge.
  always_comb begin
    m0_gnt        = gnt0;
    m1_gnt        = gnt1;
    mem_read      = cmd_q.read & ~reset;
    mem_write     = cmd_q.write & ~reset;
    store_size    = cmd_q.size;
    load_size     = cmd_q.size;
    load_unsigned = cmd_q.uns;
    endereco      = cmd_q.addr;
    write_data    = cmd_q.wdata;
    resp_load     = tag_s2_q.valid & tag_s2_q.is_load & ~reset;
    m0_rvalid     = resp_load & (tag_s2_q.port == PORT_CPU);
    m1_rvalid     = resp_load & (tag_s2_q.port == PORT_AUX);
    m0_rdata      = m0_rvalid ? read_data : '0;
    m1_rdata      = m1_rvalid ? read_data : '0;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vectors, corner sequences and a randomized model check.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int RAND_CYCLES = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_unsigned, m1_req, m1_we, m1_unsigned;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  store_size, load_size;
  logic [31:0] endereco, write_data, read_data;

  // Fixed-priority instance, only its grants are examined.
  logic        f_m0_req, f_m1_req, f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_endereco, f_write_data;
  logic        f_mem_read, f_mem_write, f_load_unsigned;
  logic [1:0]  f_store_size, f_load_size;
  logic [31:0] f_read_data = 32'h0;

  logic [31:0] mem    [256];
  logic [31:0] shadow [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.RR_ENABLE(1)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .store_size(store_size),
    .load_size(load_size), .load_unsigned(load_unsigned), .endereco(endereco),
    .write_data(write_data), .read_data(read_data)
  );

  data_mem_arbiter #(.RR_ENABLE(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(f_m0_req), .m0_we(1'b0), .m0_size(SZ_WORD), .m0_unsigned(1'b0),
    .m0_addr(32'h0), .m0_wdata(32'h0), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid),
    .m0_rdata(f_m0_rdata),
    .m1_req(f_m1_req), .m1_we(1'b0), .m1_size(SZ_WORD), .m1_unsigned(1'b0),
    .m1_addr(32'h4), .m1_wdata(32'h0), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid),
    .m1_rdata(f_m1_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .store_size(f_store_size),
    .load_size(f_load_size), .load_unsigned(f_load_unsigned), .endereco(f_endereco),
    .write_data(f_write_data), .read_data(f_read_data)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'h8765_4321 ^ (32'(i) * 32'h0101_0307);
  endfunction

  function automatic logic [31:0] load_ext(logic [31:0] w, logic [1:0] a, logic [1:0] sz,
                                           logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    if (sz[1]) return w;
    if (sz[0]) return uns ? {16'h0, h} : {{16{h[15]}}, h};
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] store_merge(logic [31:0] w, logic [1:0] a, logic [1:0] sz,
                                              logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz[1]) r = d;
    else if (sz[0]) r[{a[1], 4'b0000} +: 16] = d[15:0];
    else r[{a, 3'b000} +: 8] = d[7:0];
    return r;
  endfunction

  // Synchronous-read memory driven by the DUT command outputs.
  always @(posedge clk) begin
    if (mem_write)
      mem[endereco[9:2]] = store_merge(mem[endereco[9:2]], endereco[1:0], store_size, write_data);
    if (mem_read)
      read_data <= load_ext(mem[endereco[9:2]], endereco[1:0], load_size, load_unsigned);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_size = sz; m0_unsigned = uns; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_size = sz; m1_unsigned = uns; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  vec_t  vecs[11];
  resp_t q0[$];
  resp_t q1[$];

  initial begin
    logic        r_req[2], r_we[2], r_uns[2], pend[2];
    logic [1:0]  r_sz[2];
    logic [31:0] r_addr[2], r_wd[2];
    logic        exp_v;
    logic [31:0] exp_d;
    int          win, ref_last, lane;

    vecs[0]  = '{0, 1'b0, SZ_WORD, 1'b0, 32'h28, 32'h0,        32'h1234_5678};
    vecs[1]  = '{1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0,        32'h0000_0080};
    vecs[2]  = '{1, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0,        32'hFFFF_FF80};
    vecs[3]  = '{0, 1'b0, SZ_HALF, 1'b0, 32'h2A, 32'h0,        32'h0000_1234};
    vecs[4]  = '{0, 1'b1, SZ_BYTE, 1'b0, 32'h28, 32'hCAFE_00AB, 32'h0};
    vecs[5]  = '{1, 1'b0, SZ_WORD, 1'b0, 32'h28, 32'h0,        32'h1234_56AB};
    vecs[6]  = '{0, 1'b1, SZ_HALF, 1'b0, 32'h2E, 32'h1111_BEEF, 32'h0};
    vecs[7]  = '{0, 1'b0, SZ_HALF, 1'b0, 32'h2E, 32'h0,        32'hFFFF_BEEF};
    vecs[8]  = '{1, 1'b0, SZ_HALF, 1'b1, 32'h2E, 32'h0,        32'h0000_BEEF};
    vecs[9]  = '{1, 1'b0, SZ_BYTE, 1'b0, 32'h2F, 32'h0,        32'hFFFF_FFBE};
    vecs[10] = '{0, 1'b0, 2'b11,   1'b0, 32'h2C, 32'h0,        32'hBEEF_0000};

    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    mem[10] = 32'h1234_5678;
    mem[4]  = 32'h8000_0000;
    mem[11] = 32'h0;
    read_data = 32'h0;
    f_m0_req = 1'b0;
    f_m1_req = 1'b0;
    drive(0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);

    // Reset state.
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("rst_m0_gnt", m0_gnt, 0);      check("rst_m1_gnt", m1_gnt, 0);
    check("rst_m0_rvalid", m0_rvalid, 0); check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_mem_read", mem_read, 0);  check("rst_mem_write", mem_write, 0);
    check("rst_endereco", endereco, 0);  check("rst_write_data", write_data, 0);
    check("rst_sizes", {store_size, load_size, load_unsigned}, 0);
    check("rst_rdata", m0_rdata | m1_rdata, 0);
    tick();

    // Both ports contend for 4 cycles: grants alternate starting with port 0.
    for (int k = 0; k < 6; k++) begin
      drive(0, k < 4, 1'b0, SZ_WORD, 1'b0, 32'h28, 32'h0);
      drive(1, k < 4, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
      #1;
      check($sformatf("rr%0d_m0_gnt", k), m0_gnt, (k < 4) && (k % 2 == 0));
      check($sformatf("rr%0d_m1_gnt", k), m1_gnt, (k < 4) && (k % 2 == 1));
      check($sformatf("rr%0d_m0_rvalid", k), m0_rvalid, (k >= 2) && (k % 2 == 0));
      check($sformatf("rr%0d_m1_rvalid", k), m1_rvalid, (k >= 2) && (k % 2 == 1));
      check($sformatf("rr%0d_m0_rdata", k), m0_rdata,
            ((k >= 2) && (k % 2 == 0)) ? 32'h1234_5678 : 32'h0);
      check($sformatf("rr%0d_m1_rdata", k), m1_rdata,
            ((k >= 2) && (k % 2 == 1)) ? 32'h8000_0000 : 32'h0);
      tick();
    end

    // Directed single-port vectors: grant, command, response.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
            vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_gnt_own", i), vecs[i].port == 0 ? m0_gnt : m1_gnt, 1);
      check($sformatf("vec%0d_gnt_other", i), vecs[i].port == 0 ? m1_gnt : m0_gnt, 0);
      tick();
      drive(vecs[i].port, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'hFFFF_FFFC, 32'h0);
      #1;
      check($sformatf("vec%0d_mem_read", i), mem_read, !vecs[i].we);
      check($sformatf("vec%0d_mem_write", i), mem_write, vecs[i].we);
      check($sformatf("vec%0d_endereco", i), endereco, vecs[i].addr);
      check($sformatf("vec%0d_write_data", i), write_data, vecs[i].wdata);
      check($sformatf("vec%0d_sizes", i), {store_size, load_size, load_unsigned},
            {vecs[i].size, vecs[i].size, vecs[i].uns});
      tick();
      #1;
      check($sformatf("vec%0d_idle_strobes", i), {mem_read, mem_write}, 0);
      check($sformatf("vec%0d_hold_addr", i), endereco, vecs[i].addr);
      check($sformatf("vec%0d_rvalid_own", i), vecs[i].port == 0 ? m0_rvalid : m1_rvalid,
            !vecs[i].we);
      check($sformatf("vec%0d_rvalid_other", i), vecs[i].port == 0 ? m1_rvalid : m0_rvalid, 0);
      check($sformatf("vec%0d_rdata", i), vecs[i].port == 0 ? m0_rdata : m1_rdata,
            vecs[i].exp_rdata);
      tick();
    end

    // Store from port 0 followed immediately by a load of the same word from port 1.
    drive(0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
    #1;
    check("fwd_m0_gnt", m0_gnt, 1);
    tick();
    drive(0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    check("fwd_m1_gnt", m1_gnt, 1);
    tick();
    drive(1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    #1;
    check("fwd_no_early_rvalid", m1_rvalid, 0);
    tick();
    #1;
    check("fwd_m1_rvalid", m1_rvalid, 1);
    check("fwd_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    tick();

    // Reset one cycle after a load is accepted discards it.
    drive(0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h28, 32'h0);
    #1;
    check("rstmid_m0_gnt", m0_gnt, 1);
    tick();
    drive(0, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h28, 32'h0);
    reset = 1'b1;
    #1;
    check("rstmid_no_gnt", {m0_gnt, m1_gnt}, 0);
    tick();
    reset = 1'b0;
    drive(1, 1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h0, 32'h0);
    #1;
    check("rstmid_rvalid", {m0_rvalid, m1_rvalid}, 0);
    check("rstmid_rdata", m0_rdata | m1_rdata, 0);
    check("rstmid_strobes", {mem_read, mem_write}, 0);
    check("rstmid_endereco", endereco, 0);
    check("rstmid_write_data", write_data, 0);
    check("rstmid_sizes", {store_size, load_size, load_unsigned}, 0);
    tick();
    #1;
    check("rstmid_rvalid_late", {m0_rvalid, m1_rvalid}, 0);
    tick();

    // Fixed-priority instance: port 0 always wins, port 1 gets in once port 0 drops.
    for (int k = 0; k < 4; k++) begin
      f_m0_req = (k < 3);
      f_m1_req = 1'b1;
      #1;
      check($sformatf("fp%0d_m0_gnt", k), f_m0_gnt, k < 3);
      check($sformatf("fp%0d_m1_gnt", k), f_m1_gnt, k == 3);
      tick();
    end
    f_m0_req = 1'b0;
    f_m1_req = 1'b0;

    // Randomized traffic against a transaction-level model.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = init_word(i);
      shadow[i] = init_word(i);
    end
    ref_last = 1;
    pend[0]  = 1'b0;
    pend[1]  = 1'b0;
    for (int c = 0; c < RAND_CYCLES + 8; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          r_req[p] = (c < RAND_CYCLES) && ($urandom_range(0, 3) != 0);
          r_we[p]  = ($urandom_range(0, 2) == 0);
          r_sz[p]  = 2'($urandom_range(0, 3));
          r_uns[p] = 1'($urandom_range(0, 1));
          r_wd[p]  = $urandom;
          lane     = $urandom_range(0, 3);
          if (r_sz[p][1]) lane = 0;
          else if (r_sz[p][0]) lane = lane & 2;
          r_addr[p] = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'(lane);
        end
        drive(p, r_req[p], r_we[p], r_sz[p], r_uns[p], r_addr[p], r_wd[p]);
      end
      #1;
      if (r_req[0] && r_req[1]) win = (ref_last == 1) ? 0 : 1;
      else if (r_req[0]) win = 0;
      else if (r_req[1]) win = 1;
      else win = -1;
      check($sformatf("rnd%0d_m0_gnt", c), m0_gnt, win == 0);
      check($sformatf("rnd%0d_m1_gnt", c), m1_gnt, win == 1);

      exp_v = (q0.size() > 0) && (q0[0].due == c);
      exp_d = exp_v ? q0[0].data : 32'h0;
      if (exp_v) void'(q0.pop_front());
      check($sformatf("rnd%0d_m0_rvalid", c), m0_rvalid, exp_v);
      check($sformatf("rnd%0d_m0_rdata", c), m0_rdata, exp_d);
      exp_v = (q1.size() > 0) && (q1[0].due == c);
      exp_d = exp_v ? q1[0].data : 32'h0;
      if (exp_v) void'(q1.pop_front());
      check($sformatf("rnd%0d_m1_rvalid", c), m1_rvalid, exp_v);
      check($sformatf("rnd%0d_m1_rdata", c), m1_rdata, exp_d);

      if (win >= 0) begin
        ref_last = win;
        if (r_we[win]) begin
          shadow[r_addr[win][9:2]] = store_merge(shadow[r_addr[win][9:2]], r_addr[win][1:0],
                                                 r_sz[win], r_wd[win]);
        end else if (win == 0) begin
          q0.push_back('{c + 2, load_ext(shadow[r_addr[0][9:2]], r_addr[0][1:0], r_sz[0],
                                         r_uns[0])});
        end else begin
          q1.push_back('{c + 2, load_ext(shadow[r_addr[1][9:2]], r_addr[1][1:0], r_sz[1],
                                         r_uns[1])});
        end
      end
      for (int p = 0; p < 2; p++) pend[p] = r_req[p] && (p != win);
      tick();
    end
    check("rnd_drained", 32'(q0.size() + q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
